// File: rtl/aosf1_types_pkg.sv
// AOSF1Types: shared SoftReg/AXI-Lite definitions for the F1 register fabric.
//   - SoftRegReq / SoftRegResp  : 64-bit SoftReg request/response bundles
//   - F1_SR2AXIL_TIMEOUT_CYCLES : default response watchdog limit
//   - F1_SR2AXIL_TIMEOUT_DATA   : read data returned when the watchdog fires
//   - AXI_RESP_*                : AXI-Lite BRESP/RRESP encodings
package AOSF1Types;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    localparam int          F1_SR2AXIL_TIMEOUT_CYCLES = 1024;
    localparam logic [63:0] F1_SR2AXIL_TIMEOUT_DATA   = 64'hDEADDEAD_DEADDEAD;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/sr2axil_master.sv
// sr2axil_master: converts one 64-bit SoftReg request at a time into two
// 32-bit AXI-Lite beats (low word at addr[W-1:3]+0, high word at +4) and
// reassembles read beats into a single 64-bit SoftReg response.
//
// Ports:
//   clk_main_a0, rst_main_n           clock, asynchronous active-low reset
//   sr_req_valid/isWrite/addr/data    SoftReg request in
//   sr_req_grant                      request accepted (combinational, IDLE only)
//   sr_resp_valid/data                one-cycle read response pulse, data held
//   m_axil_aw*/w*/b*/ar*/r*           AXI-Lite master channels (outputs registered)
//   axil_err                          sticky error flag, cleared only by reset
//
// Optional feature macro: SR2AXIL_TIMEOUT_EN -- response watchdog of
// TIMEOUT_CYCLES; on expiry the block flags an error, returns the timeout
// pattern for reads and refuses further requests until reset.
module sr2axil_master
    import AOSF1Types::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = F1_SR2AXIL_TIMEOUT_CYCLES
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    input  logic                  sr_req_valid,
    input  logic                  sr_req_isWrite,
    input  logic [ADDR_WIDTH-1:0] sr_req_addr,
    input  logic [63:0]           sr_req_data,
    output logic                  sr_req_grant,
    output logic                  sr_resp_valid,
    output logic [63:0]           sr_resp_data,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic                  axil_err
);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP} state_t;

    state_t                state_reg;
    logic                  beat_reg;      // 0 = low word, 1 = high word
    logic [ADDR_WIDTH-4:0] addr_hi_reg;   // 8-byte aligned request address
    logic [31:0]           wr_hi_reg;     // high write word, issued on the second beat
    logic [31:0]           rd_lo_reg;     // low read word, held until the high beat returns

    // Byte offset [2:0] is ignored: beats always land on +0 and +4.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^sr_req_addr[2:0];

`ifdef SR2AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             tmo_dead_reg;   // watchdog fired; block is parked until reset
    logic             tmo_hit;
    // Fires on the last cycle of the window so the response is visible
    // exactly TIMEOUT_CYCLES cycles after entering the wait state.
    assign tmo_hit      = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign sr_req_grant = sr_req_valid && (state_reg == IDLE) && !tmo_dead_reg;
`else
    logic unused_tmo;
    assign unused_tmo   = (TIMEOUT_CYCLES != 0);
    assign sr_req_grant = sr_req_valid && (state_reg == IDLE);
`endif

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_reg      <= IDLE;
            beat_reg       <= 1'b0;
            addr_hi_reg    <= '0;
            wr_hi_reg      <= '0;
            rd_lo_reg      <= '0;
            sr_resp_valid  <= 1'b0;
            sr_resp_data   <= '0;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            axil_err       <= 1'b0;
`ifdef SR2AXIL_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
            tmo_dead_reg   <= 1'b0;
`endif
        end else begin
            sr_resp_valid <= 1'b0;
`ifdef SR2AXIL_TIMEOUT_EN
            // Counter runs only while waiting for B/R; any other state clears
            // it, so every entry into a wait state starts from zero.
            if (state_reg == WR_RESP || state_reg == RD_RESP)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            else
                tmo_cnt_reg <= '0;
`endif
            case (state_reg)
                IDLE: begin
                    if (sr_req_grant) begin
                        addr_hi_reg <= sr_req_addr[ADDR_WIDTH-1:3];
                        wr_hi_reg   <= sr_req_data[63:32];
                        beat_reg    <= 1'b0;
                        if (sr_req_isWrite) begin
                            m_axil_awaddr  <= {sr_req_addr[ADDR_WIDTH-1:3], 3'b000};
                            m_axil_wdata   <= sr_req_data[31:0];
                            m_axil_wstrb   <= 4'hF;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state_reg      <= WR_ISSUE;
                        end else begin
                            m_axil_araddr  <= {sr_req_addr[ADDR_WIDTH-1:3], 3'b000};
                            m_axil_arvalid <= 1'b1;
                            state_reg      <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    // AW and W retire independently; a dropped valid marks
                    // that channel as already done for this beat.
                    if (m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
                    if ((!m_axil_awvalid || m_axil_awready) &&
                        (!m_axil_wvalid  || m_axil_wready)) begin
                        m_axil_bready <= 1'b1;
                        state_reg     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        if (m_axil_bresp != AXI_RESP_OKAY) axil_err <= 1'b1;
                        if (!beat_reg) begin
                            beat_reg       <= 1'b1;
                            m_axil_awaddr  <= {addr_hi_reg, 3'b100};
                            m_axil_wdata   <= wr_hi_reg;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state_reg      <= WR_ISSUE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
`ifdef SR2AXIL_TIMEOUT_EN
                    else if (tmo_hit) begin
                        m_axil_bready <= 1'b0;
                        axil_err      <= 1'b1;
                        tmo_dead_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
`endif
                end
                RD_ISSUE: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state_reg      <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        if (m_axil_rresp != AXI_RESP_OKAY) axil_err <= 1'b1;
                        if (!beat_reg) begin
                            rd_lo_reg      <= m_axil_rdata;
                            beat_reg       <= 1'b1;
                            m_axil_araddr  <= {addr_hi_reg, 3'b100};
                            m_axil_arvalid <= 1'b1;
                            state_reg      <= RD_ISSUE;
                        end else begin
                            sr_resp_valid <= 1'b1;
                            sr_resp_data  <= {m_axil_rdata, rd_lo_reg};
                            state_reg     <= IDLE;
                        end
                    end
`ifdef SR2AXIL_TIMEOUT_EN
                    else if (tmo_hit) begin
                        m_axil_rready <= 1'b0;
                        axil_err      <= 1'b1;
                        tmo_dead_reg  <= 1'b1;
                        sr_resp_valid <= 1'b1;
                        sr_resp_data  <= F1_SR2AXIL_TIMEOUT_DATA;
                        state_reg     <= IDLE;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr2axil_master.sv
// Self-checking bench for sr2axil_master: AXI-Lite slave model with optional
// random stalls, scoreboard queues for expected AW/W/AR beats and SoftReg
// read responses, plus directed timing, error, reset and timeout steps.
`timescale 1ns/1ps
module tb_sr2axil_master;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sr_req_valid = 1'b0, sr_req_isWrite = 1'b0;
    logic [AW-1:0] sr_req_addr = '0;
    logic [63:0]   sr_req_data = '0;
    logic          sr_req_grant, sr_resp_valid, axil_err;
    logic [63:0]   sr_resp_data;
    logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
    logic          m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
    logic [31:0]   m_axil_wdata;
    logic [3:0]    m_axil_wstrb;
    logic          m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_arready = 1'b0;
    logic          m_axil_bvalid = 1'b0, m_axil_rvalid = 1'b0;
    logic [1:0]    m_axil_bresp = '0, m_axil_rresp = '0;
    logic [31:0]   m_axil_rdata = '0;

    always #5 clk = ~clk;

    sr2axil_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .sr_req_valid(sr_req_valid), .sr_req_isWrite(sr_req_isWrite),
        .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data), .sr_req_grant(sr_req_grant),
        .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
        .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
        .m_axil_rready(m_axil_rready),
        .axil_err(axil_err)
    );

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- slave model and scoreboard ----------------
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];
    logic [31:0] aw_q[$], wd_q[$], b_q[$], r_q[$];
    logic [31:0] exp_aw_q[$], exp_wd_q[$], exp_ar_q[$];
    logic [63:0] exp_rd_q[$];
    bit stall_en = 0, r_hold = 0, err_low = 0;
    int resp_cnt = 0, last_resp_cyc = 0, aw_hs_cnt = 0, aw_first = 0, w_first = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction
    function automatic int rnd_st();
        return stall_en ? int'($urandom_range(0, 7)) : 0;
    endfunction
    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
    endfunction

    initial begin
        int aw_st = 0, w_st = 0, ar_st = 0, b_dly = 0, r_dly = 0, aw_pre, wd_pre;
        bit b_fired = 0, r_fired = 0, aw_wait = 0, w_wait = 0, ar_wait = 0;
        logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0, a, d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_q.delete(); wd_q.delete(); b_q.delete(); r_q.delete();
                m_axil_bvalid = 0; m_axil_rvalid = 0;
                m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
                b_fired = 0; r_fired = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (sr_resp_valid) begin
                    resp_cnt++;
                    last_resp_cyc = cyc;
                    if (exp_rd_q.size() == 0) check("resp_unexpected", 64'(sr_resp_valid), 64'd0);
                    else check("resp_data", sr_resp_data, exp_rd_q.pop_front());
                end
                // B and R first so a beat completing now answers next cycle at the earliest
                if (b_fired) begin m_axil_bvalid = 0; b_fired = 0; end
                if (!m_axil_bvalid && b_q.size() > 0) begin
                    if (b_dly == 0) begin
                        m_axil_bvalid = 1;
                        m_axil_bresp = (err_low && b_q[0][2] == 1'b0) ? 2'b10 : 2'b00;
                        void'(b_q.pop_front());
                        b_dly = rnd_st();
                    end else b_dly--;
                end
                if (m_axil_bvalid && m_axil_bready) b_fired = 1;
                if (r_fired) begin m_axil_rvalid = 0; r_fired = 0; end
                if (!m_axil_rvalid && r_q.size() > 0 && !r_hold) begin
                    if (r_dly == 0) begin
                        a = r_q.pop_front();
                        m_axil_rvalid = 1;
                        m_axil_rdata = slv_mem.exists(a) ? slv_mem[a] : dflt(a);
                        m_axil_rresp = 2'b00;
                        r_dly = rnd_st();
                    end else r_dly--;
                end
                if (m_axil_rvalid && m_axil_rready) r_fired = 1;
                aw_pre = aw_q.size();
                wd_pre = wd_q.size();
                // AW
                if (aw_wait) check("aw_stable", {31'd0, m_axil_awvalid, m_axil_awaddr}, {31'd0, 1'b1, aw_prev});
                aw_wait = 0;
                if (m_axil_awvalid) begin
                    if (aw_st == 0) begin
                        m_axil_awready = 1;
                        if (exp_aw_q.size() == 0) check("aw_unexpected", 64'(m_axil_awvalid), 64'd0);
                        else check("awaddr", 64'(m_axil_awaddr), 64'(exp_aw_q.pop_front()));
                        if (wd_pre > 0) w_first++;
                        aw_q.push_back(m_axil_awaddr);
                        aw_hs_cnt++;
                        aw_st = rnd_st();
                    end else begin
                        m_axil_awready = 0; aw_st--; aw_wait = 1; aw_prev = m_axil_awaddr;
                    end
                end else m_axil_awready = 0;
                // W
                if (w_wait) check("w_stable", {31'd0, m_axil_wvalid, m_axil_wdata}, {31'd0, 1'b1, w_prev});
                w_wait = 0;
                if (m_axil_wvalid) begin
                    if (w_st == 0) begin
                        m_axil_wready = 1;
                        if (exp_wd_q.size() == 0) check("w_unexpected", 64'(m_axil_wvalid), 64'd0);
                        else check("wdata", 64'(m_axil_wdata), 64'(exp_wd_q.pop_front()));
                        check("wstrb", 64'(m_axil_wstrb), 64'hF);
                        if (aw_pre > 0) aw_first++;
                        wd_q.push_back(m_axil_wdata);
                        w_st = rnd_st();
                    end else begin
                        m_axil_wready = 0; w_st--; w_wait = 1; w_prev = m_axil_wdata;
                    end
                end else m_axil_wready = 0;
                while (aw_q.size() > 0 && wd_q.size() > 0) begin
                    a = aw_q.pop_front();
                    d = wd_q.pop_front();
                    slv_mem[a] = d;
                    b_q.push_back(a);
                end
                // AR
                if (ar_wait) check("ar_stable", {31'd0, m_axil_arvalid, m_axil_araddr}, {31'd0, 1'b1, ar_prev});
                ar_wait = 0;
                if (m_axil_arvalid) begin
                    if (ar_st == 0) begin
                        m_axil_arready = 1;
                        if (exp_ar_q.size() == 0) check("ar_unexpected", 64'(m_axil_arvalid), 64'd0);
                        else check("araddr", 64'(m_axil_araddr), 64'(exp_ar_q.pop_front()));
                        r_q.push_back(m_axil_araddr);
                        ar_st = rnd_st();
                    end else begin
                        m_axil_arready = 0; ar_st--; ar_wait = 1; ar_prev = m_axil_araddr;
                    end
                end else m_axil_arready = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic sr_op(input bit wr, input logic [31:0] addr, input logic [63:0] data, output int gcyc);
        logic [31:0] base;
        int n = 0;
        base = {addr[31:3], 3'b000};
        @(negedge clk);
        sr_req_valid = 1; sr_req_isWrite = wr; sr_req_addr = addr; sr_req_data = data;
        #1;
        while (!sr_req_grant && n < 300) begin @(negedge clk); #1; n++; end
        gcyc = cyc;
        if (!sr_req_grant) check("grant_timeout", 64'(sr_req_grant), 64'd1);
        else if (wr) begin
            exp_aw_q.push_back(base); exp_aw_q.push_back(base | 32'd4);
            exp_wd_q.push_back(data[31:0]); exp_wd_q.push_back(data[63:32]);
            mdl_mem[base] = data[31:0];
            mdl_mem[base | 32'd4] = data[63:32];
        end else begin
            exp_ar_q.push_back(base); exp_ar_q.push_back(base | 32'd4);
            exp_rd_q.push_back({mdl_rd(base | 32'd4), mdl_rd(base)});
        end
        @(negedge clk);
        sr_req_valid = 0;
    endtask

    task automatic wait_resp(input int target, input string tag);
        int n = 0;
        while (resp_cnt < target && n < 300) begin @(negedge clk); #1; n++; end
        check(tag, 64'(resp_cnt), 64'(target));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int g0, g1, g, n, e, aw0, rc;
        logic [31:0] wa, ra;
        slv_mem[32'h2000] = 32'hAAAA0001; mdl_mem[32'h2000] = 32'hAAAA0001;
        slv_mem[32'h2004] = 32'hBBBB0002; mdl_mem[32'h2004] = 32'hBBBB0002;
        repeat (3) @(negedge clk);
        #1;
        check("rst_awvalid", 64'(m_axil_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_axil_wvalid), 64'd0);
        check("rst_arvalid", 64'(m_axil_arvalid), 64'd0);
        check("rst_readies", {62'd0, m_axil_bready, m_axil_rready}, 64'd0);
        check("rst_wstrb", 64'(m_axil_wstrb), 64'd0);
        check("rst_resp", {63'd0, sr_resp_valid} | sr_resp_data, 64'd0);
        check("rst_err", 64'(axil_err), 64'd0);
        @(negedge clk);
        rst_n = 1;

        // zero-wait write then read, with cycle-accurate spacing
        stall_en = 0;
        sr_op(1, 32'h1004, 64'h11223344_55667788, g0);
        sr_op(0, 32'h2000, 64'd0, g1);
        check("wr_regrant_gap", 64'(g1 - g0), 64'd5);
        wait_resp(1, "rd_resp_seen");
        check("rd_resp_latency", 64'(last_resp_cyc - g1), 64'd5);
        @(negedge clk); #1;
        check("rd_resp_single_pulse", 64'(sr_resp_valid), 64'd0);
        check("rd_resp_data_hold", sr_resp_data, 64'hBBBB0002_AAAA0001);

        // random stalls on every channel, 100 write/read pairs
        stall_en = 1;
        for (int i = 0; i < 100; i++) begin
            wa = 32'h4000 | (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
            sr_op(1, wa, {$urandom, $urandom}, g);
            ra = 32'h4000 | (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
            sr_op(0, ra, 64'd0, g);
        end
        wait_resp(101, "rand_resp_count");
        n = 0;
        while ((exp_aw_q.size() + exp_wd_q.size() + exp_ar_q.size() + exp_rd_q.size()) != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        check("rand_drain", 64'(exp_aw_q.size() + exp_wd_q.size() + exp_ar_q.size() + exp_rd_q.size()), 64'd0);
        check("aw_before_w_seen", 64'(aw_first > 0), 64'd1);
        check("w_before_aw_seen", 64'(w_first > 0), 64'd1);
        check("err_before_inject", 64'(axil_err), 64'd0);

        // SLVERR on the low beat: high beat still goes out, error sticks
        stall_en = 0;
        err_low = 1;
        aw0 = aw_hs_cnt;
        sr_op(1, 32'h3000, 64'hCAFEF00D_12345678, g);
        repeat (8) @(negedge clk);
        err_low = 0;
        #1;
        check("err_both_beats", 64'(aw_hs_cnt - aw0), 64'd2);
        check("err_sticky", 64'(axil_err), 64'd1);
        sr_op(0, 32'h3000, 64'd0, g);
        wait_resp(102, "err_rd_resp");
        check("err_still_set", 64'(axil_err), 64'd1);

        // reset while waiting in RD_RESP
        r_hold = 1;
        sr_op(0, 32'h5000, 64'd0, g);
        n = 0;
        while (!m_axil_rready && n < 50) begin @(negedge clk); #1; n++; end
        check("rst_test_in_rd_resp", 64'(m_axil_rready), 64'd1);
        #2;
        rst_n = 0;
        #1;
        check("midrst_rready", 64'(m_axil_rready), 64'd0);
        check("midrst_valids", {61'd0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 64'd0);
        check("midrst_err", 64'(axil_err), 64'd0);
        check("midrst_resp_data", sr_resp_data, 64'd0);
        repeat (2) @(negedge clk);
        exp_rd_q.delete(); exp_ar_q.delete();
        r_hold = 0;
        rst_n = 1;
        rc = resp_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("no_resp_after_reset", 64'(resp_cnt), 64'(rc));
        sr_op(0, 32'h2004, 64'd0, g);
        wait_resp(rc + 1, "post_reset_read");

`ifdef SR2AXIL_TIMEOUT_EN
        // read with no R response: watchdog answers with the timeout pattern
        r_hold = 1;
        rc = resp_cnt;
        sr_op(0, 32'h6000, 64'd0, g);
        exp_rd_q.delete();
        exp_rd_q.push_back(64'hDEADDEAD_DEADDEAD);
        n = 0;
        while (!m_axil_rready && n < 50) begin @(negedge clk); #1; n++; end
        e = cyc;
        wait_resp(rc + 1, "tmo_resp_seen");
        check("tmo_latency", 64'(last_resp_cyc - e), 64'd16);
        check("tmo_err", 64'(axil_err), 64'd1);
        check("tmo_rready_low", 64'(m_axil_rready), 64'd0);
        exp_ar_q.delete();
        @(negedge clk);
        sr_req_valid = 1; sr_req_isWrite = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("tmo_no_grant", 64'(sr_req_grant), 64'd0);
            @(negedge clk);
        end
        sr_req_valid = 0;
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sr2axil_master.md
# sr2axil_master

Converts 64-bit SoftReg requests into 32-bit AXI-Lite master transactions, splitting each request into a low beat and a high beat and reassembling read data into a single SoftReg response. It drives AXI-Lite slaves across the F1 SoftReg route tree, register-extender hops and simulation harnesses, and is the initiator side of the AXI-Lite-to-SoftReg bridge. It processes one request at a time.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI-Lite and SoftReg address width.
- TIMEOUT_CYCLES, 1024, response-wait watchdog limit; used only with SR2AXIL_TIMEOUT_EN.

Ports (clock and reset first):
- clk_main_a0  in  1  sole clock; all logic on rising edge.
- rst_main_n  in  1  asynchronous, active-low reset.
- sr_req_valid  in  1  SoftReg request present.
- sr_req_isWrite  in  1  1 = write, 0 = read.
- sr_req_addr  in  ADDR_WIDTH  byte address; bits [2:0] ignored.
- sr_req_data  in  64  write data.
- sr_req_grant  out  1  request accepted this cycle.
- sr_resp_valid  out  1  one-cycle read-data pulse; no backpressure.
- sr_resp_data  out  64  read data.
- m_axil_awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1
- m_axil_wdata / wstrb / wvalid / wready  out / out / out / in  32 / 4 / 1 / 1
- m_axil_bresp / bvalid / bready  in / in / out  2 / 1 / 1
- m_axil_araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1
- m_axil_rdata / rresp / rvalid / rready  in / in / in / out  32 / 2 / 1 / 1
- axil_err  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP. A beat bit selects low (0) or high (1).
- IDLE:
  - sr_req_grant = sr_req_valid (combinational). Only IDLE grants.
  - On grant: capture addr, data and isWrite. Clear the beat bit. Go to WR_ISSUE or RD_ISSUE.
- Beat addresses:
  - Low beat: {addr[W-1:3], 3'b000}.
  - High beat: {addr[W-1:3], 3'b100}.
  - No carry arithmetic.
- WR_ISSUE:
  - Assert awvalid and wvalid. wdata = data[31:0] for the low beat, data[63:32] for the high beat. wstrb = 4'hF.
  - The AW and W handshakes complete independently. Each valid drops after its own handshake.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid: if bresp != 2'b00, set axil_err.
  - Low beat: set the beat bit and return to WR_ISSUE.
  - High beat: go to IDLE. Writes produce no SoftReg response.
- RD_ISSUE: assert arvalid. On arready, go to RD_RESP.
- RD_RESP:
  - rready = 1.
  - On rvalid: capture rdata into the matching half; if rresp != 2'b00, set axil_err.
  - Low beat: return to RD_ISSUE with the beat bit set.
  - High beat: go to IDLE and pulse sr_resp_valid in the next cycle.
- Error responses do not abort the sequence. Both beats are always issued.
- Reset values: every output is 0, state IDLE, axil_err 0.
- Reset mid-transaction: all valids drop immediately (asynchronous). The in-flight request and any pending response are discarded.

## Timing
- Zero-wait slave, grant in cycle 0:
  - Write: AW/W low in cycle 1, B low in cycle 2, AW/W high in cycle 3, B high in cycle 4. IDLE in cycle 5, where a new grant is possible.
  - Read: AR low in cycle 1, R low in cycle 2, AR high in cycle 3, R high in cycle 4. sr_resp_valid in cycle 5, same cycle as IDLE.
- All AXI outputs are registered. valid is never withdrawn before its ready.
- sr_resp_data holds its value until the next read completes.
- Throughput is at most one request per 5 cycles.

## Configuration
- SR2AXIL_TIMEOUT_EN defined:
  - A counter runs in WR_RESP and RD_RESP and resets on each state entry.
  - When the counter reaches TIMEOUT_CYCLES: set axil_err and go to IDLE.
  - A read timeout additionally pulses sr_resp_valid with sr_resp_data = 64'hDEADDEAD_DEADDEAD.
  - After any timeout, bready and rready stay 0 and grant stays 0 until reset.
- SR2AXIL_TIMEOUT_EN undefined: no counter; the block waits indefinitely for responses.

## Structure
- The AOSF1Types package holds:
  - the SoftRegReq and SoftRegResp typedefs;
  - the F1_SR2AXIL_TIMEOUT_CYCLES default;
  - the timeout data pattern;
  - the AXI response encoding constants.
- The state enum stays local to the module.
- Single module; no sub-module is warranted.

## Test plan
- Write at addr 0x1004, data 0x11223344_55667788, zero-wait slave:
  - awaddr 0x1000 with wdata 0x55667788, then 0x1004 with 0x11223344.
  - No sr_resp_valid; grant possible again 5 cycles after accept.
- Read at addr 0x2000; slave returns 0xAAAA0001 then 0xBBBB0002:
  - sr_resp_valid pulses once with data 0xBBBB0002_AAAA0001.
- Random ready/valid stalls of 0–7 cycles on every channel:
  - valids remain stable until their handshakes.
  - AW-before-W and W-before-AW orderings both complete.
  - 100 read/write pairs match a scoreboard.
- Slave returns bresp = 2'b10 on the low beat: the high beat is still issued, and axil_err = 1 until reset.
- Reset asserted during RD_RESP: outputs go to 0 within the same cycle, and no sr_resp_valid appears after release.
- With SR2AXIL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a read with rvalid never asserted:
  - sr_resp_valid with 0xDEADDEAD_DEADDEAD 16 cycles after entering RD_RESP.
  - axil_err = 1, and no further grants.
